// File: rtl/adder_slice_sequencer_pkg.sv
// Shared types and constants for the adder slice sequencer.
// The 4-bit slice width is fixed by the external combinational adder.
package adder_seq_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int calc_nslices(input int width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/adder_slice_sequencer_if.sv
// Operand/result handshakes plus the slice link to the external 4-bit adder.
// slave: the sequencer side; master: the surrounding parent / upstream / consumer.
interface adder_slice_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic [3:0]       add_a;
    logic [3:0]       add_b;
    logic             add_cin;
    logic [3:0]       add_c;
    logic             add_cout;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, add_c, add_cout, out_ready,
        output in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, add_c, add_cout, out_ready,
        input  in_ready, add_a, add_b, add_cin, out_valid, out_sum, out_cout
    );
endinterface

// File: rtl/adder_slice_sequencer.sv
// Serialises a WIDTH-bit add through an external 4-bit adder, one slice per cycle, LSB first.
// Optional macro ADDER_SLICE_SEQ_SVA_EN embeds result/handshake assertions.
module adder_slice_sequencer
    import adder_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    adder_slice_sequencer_if.slave  bus,
    output logic                    busy
);

    localparam int NSLICES = calc_nslices(WIDTH);
    localparam int IDX_W   = $clog2(NSLICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICES - 1);

    if ((WIDTH % SLICE_W) != 0 || WIDTH < 8) begin : g_bad_width
        $error("adder_slice_sequencer: WIDTH must be a multiple of 4 and at least 8");
    end

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [3:0]         add_a_q, add_a_d, add_b_q, add_b_d;
    logic               add_cin_q, add_cin_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               in_ready_s;

    // Next-state, datapath update and handshake decode
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        carry_d    = carry_q;
        a_d        = a_q;
        b_d        = b_q;
        sum_d      = sum_q;
        in_ready_s = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_s = 1'b1;
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    carry_d = bus.in_cin;
                    idx_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d[SLICE_W*int'(idx_q) +: SLICE_W] = bus.add_c;
                carry_d = bus.add_cout;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                in_ready_s = bus.out_ready;
                if (bus.out_ready && bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    carry_d = bus.in_cin;
                    idx_d   = '0;
                    state_d = RUN;
                end else if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Adder drive and status are registered from next-state so they line up with the RUN cycle
    always_comb begin
        add_a_d     = 4'd0;
        add_b_d     = 4'd0;
        add_cin_d   = 1'b0;
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == RUN);
        if (state_d == RUN) begin
            add_a_d   = a_d[SLICE_W*int'(idx_d) +: SLICE_W];
            add_b_d   = b_d[SLICE_W*int'(idx_d) +: SLICE_W];
            add_cin_d = carry_d;
        end else begin
            add_cin_d = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            add_a_q     <= 4'd0;
            add_b_q     <= 4'd0;
            add_cin_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_cin_q   <= add_cin_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.add_cin   = add_cin_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = carry_q;
    assign busy          = busy_q;

`ifdef ADDER_SLICE_SEQ_SVA_EN
    logic cin_q;

    // Keep the original carry-in so the full-width result can be checked at DONE
    always_ff @(posedge clock) begin
        if (reset) begin
            cin_q <= 1'b0;
        end else if (bus.in_valid && in_ready_s) begin
            cin_q <= bus.in_cin;
        end else begin
            cin_q <= cin_q;
        end
    end

    a_hold_stable: assert property (@(posedge clock) disable iff (reset)
        bus.out_valid && !bus.out_ready |=> $stable(bus.out_sum) && bus.out_valid);

    a_busy_completes: assert property (@(posedge clock) disable iff (reset)
        busy |-> ##[1:NSLICES] bus.out_valid);

    a_sum_correct: assert property (@(posedge clock) disable iff (reset)
        (state_q == DONE) |->
            ({carry_q, sum_q} == ({1'b0, a_q} + {1'b0, b_q} + (WIDTH+1)'(cin_q))));
`endif

endmodule

// File: tb/tb_adder_slice_sequencer.sv
// Directed bench: scoreboard queue of expected results, decoupled negedge monitor,
// behavioural 4-bit adder closing the slice loop.
module tb_adder_slice_sequencer;

    localparam int W = 16;

    logic clock;
    logic reset;
    logic busy;
    int   checks;
    int   errors;
    int   cyc;

    logic [W:0] exp_q[$];
    int         pop_cyc_q[$];

    adder_slice_sequencer_if #(.WIDTH(W)) bus ();

    adder_slice_sequencer #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural 4-bit adder the parent would normally provide
    always_comb begin
        {bus.add_cout, bus.add_c} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'd0, bus.add_cin};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every completed output handshake must match the head of the scoreboard
    always @(negedge clock) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {15'd0, bus.out_cout, bus.out_sum}, 32'hDEAD_BEEF);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                chk("result", {15'd0, bus.out_cout, bus.out_sum}, {15'd0, e});
                pop_cyc_q.push_back(cyc);
            end
        end
    end

    // Issue one op from IDLE and check the per-slice carry sequence and latency
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic [3:0] cin_seq, input string name);
        logic [W:0] e;
        e = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        exp_q.push_back(e);
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        chk({name, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        @(posedge clock);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            bus.in_valid = 1'b0;
            chk({name, "_add_cin"}, {31'd0, bus.add_cin}, {31'd0, cin_seq[k]});
            chk({name, "_busy"}, {30'd0, busy, bus.out_valid}, 32'd2);
        end
        @(negedge clock);
        chk({name, "_latency_valid"}, {31'd0, bus.out_valid}, 32'd1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("drain", exp_q.size(), 32'd0);
        @(negedge clock);
    endtask

    initial begin
        logic [W-1:0] held;
        int n;
        checks = 0;
        errors = 0;
        cyc = 0;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_cin = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out", {15'd0, bus.out_cout, bus.out_sum}, 32'd0);
        chk("rst_add", {23'd0, bus.add_a, bus.add_b, bus.add_cin}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // Full ripple, carry-in path, single-slice carry, MSB overflow
        run_op(16'hFFFF, 16'h0001, 1'b0, 4'b1110, "ripple");
        wait_drain();
        run_op(16'h1234, 16'h4321, 1'b1, 4'b0001, "cin_path");
        wait_drain();
        run_op(16'h000F, 16'h0001, 1'b0, 4'b0010, "slice_carry");
        wait_drain();
        run_op(16'h8000, 16'h8000, 1'b1, 4'b0001, "overflow");
        wait_drain();

        // Backpressure: result must hold with in_ready low
        bus.out_ready = 1'b0;
        run_op(16'hA5A5, 16'h5A5A, 1'b0, 4'b0000, "bp");
        held = bus.out_sum;
        chk("bp_sum_value", {16'd0, held}, 32'h0000_FFFF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("bp_hold", {14'd0, bus.out_valid, bus.in_ready, bus.out_sum}, {14'd0, 2'b10, held});
        end
        bus.out_ready = 1'b1;
        wait_drain();
        chk("bp_released", {31'd0, bus.out_valid}, 32'd0);

        // Back-to-back with in_valid held high
        pop_cyc_q.delete();
        exp_q.push_back(17'h0_0003);
        exp_q.push_back(17'h0_8000);
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.in_a = 16'h0001;
        bus.in_b = 16'h0002;
        bus.in_cin = 1'b0;
        @(posedge clock);
        @(negedge clock);
        bus.in_a = 16'h7FFF;
        bus.in_b = 16'h0001;
        n = 0;
        while (!(bus.out_valid && bus.in_ready) && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("b2b_second_accept", {31'd0, bus.out_valid && bus.in_ready}, 32'd1);
        @(posedge clock);
        @(negedge clock);
        bus.in_valid = 1'b0;
        wait_drain();
        chk("b2b_count", pop_cyc_q.size(), 32'd2);
        if (pop_cyc_q.size() == 2) begin
            chk("b2b_spacing", pop_cyc_q[1] - pop_cyc_q[0], 32'd5);
        end else begin
            chk("b2b_spacing", 32'd0, 32'd5);
        end

        // Reset at idx 2: operation discarded, no output
        @(negedge clock);
        bus.in_valid = 1'b1;
        bus.in_a = 16'h1111;
        bus.in_b = 16'h2222;
        bus.in_cin = 1'b1;
        @(posedge clock);
        @(negedge clock);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clock);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mid_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("mid_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_add", {23'd0, bus.add_a, bus.add_b, bus.add_cin}, 32'd0);
        chk("mid_busy_low", {31'd0, busy}, 32'd0);
        n = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (bus.out_valid) n++;
        end
        chk("mid_no_stale", n, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
